ulpi_reg_ctrl: RTL and testbench

Sequences ULPI PHY register write and read transactions on behalf of one system requester. It drives the link's cmd/cmd_strobe transmit path and stp, and watches the PHY's dir/nxt/data. It handles RX preemption by the PHY (abort and retry) and no-response timeout. It sits between the system register-access port and the ULPI link layer.

---
 rtl/ulpi_reg_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_ulpi_reg_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// ulpi_reg_ctrl
//
// Sequences ULPI PHY register write/read transactions for a single system
// requester. Drives the link's transmit byte (cmd/cmd_strobe) and stp, and
// watches the PHY's dir/nxt/data. If the PHY takes the bus (dir high) before
// accepting the TX CMD or write data, the attempt is aborted and retried up
// to MAX_RETRY times. If nxt never arrives within TIMEOUT_CYCLES stalled
// cycles, the transaction fails.
//
// Ports
//   clk, reset                      60 MHz ULPI clock, async active-high reset
//   req_valid/req_ready             request handshake (one outstanding)
//   req_write/req_addr/req_wdata    request: 1 = write, 6-bit address, data
//   rsp_valid/rsp_rdata/rsp_error   one-cycle completion, read data, failure
//   ulpi_dir/ulpi_nxt/ulpi_data_in  PHY-driven link signals
//   cmd/cmd_strobe                  byte to transmit and its valid
//   stp                             ULPI stop
//
// Every output is a flop. The output flops are loaded from the next state,
// so each output lines up with the state that produces it.
// ---------------------------------------------------------------------------
module ulpi_reg_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] cmd,
  output logic       cmd_strobe,
  output logic       stp
);

  localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR_DATA,
    S_WR_STP,
    S_RD_TURN,
    S_RD_DATA,
    S_ABORT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RTW-1:0]   retry_q, retry_d;
  logic             low_seen_q, low_seen_d;  // ABORT: dir already seen low once
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;

  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_error_q, rsp_error_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             cmd_strobe_q, cmd_strobe_d;
  logic             stp_q, stp_d;

  // NOTE: every variable gets a default at the top of the block so that no
  // path through the case statement leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    low_seen_d = low_seen_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    cnt_inc    = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d       = req_write;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          cnt_d      = '0;
          retry_d    = '0;
          low_seen_d = 1'b0;
          err_d      = 1'b0;
          state_d    = S_CMD;
        end
      end

      S_CMD, S_WR_DATA: begin
        // dir wins over nxt: dir and nxt together is the PHY starting RX,
        // not accepting our byte.
        if (ulpi_dir) begin
          low_seen_d = 1'b0;
          state_d    = S_ABORT;
        end else if (ulpi_nxt) begin
          if (state_q == S_WR_DATA) state_d = S_WR_STP;
          else if (wr_q)            state_d = S_WR_DATA;
          else                      state_d = S_RD_TURN;
        end else begin
          // The stall budget spans CMD and WR_DATA of one attempt.
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_WR_STP: begin
        err_d   = 1'b0;
        state_d = S_RESP;
      end

      S_RD_TURN: begin
        if (ulpi_dir) begin
          state_d = S_RD_DATA;
        end else begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end

      S_RD_DATA: begin
        if (ulpi_dir) begin
          rdata_d = ulpi_data_in;
          err_d   = 1'b0;
        end else begin
          err_d   = 1'b1;
        end
        state_d = S_RESP;
      end

      S_ABORT: begin
        // Leave only after dir has been low for two consecutive samples:
        // the first low sample is the PHY's turnaround cycle.
        if (ulpi_dir) begin
          low_seen_d = 1'b0;
        end else if (!low_seen_q) begin
          low_seen_d = 1'b1;
        end else if (retry_q < RTW'(MAX_RETRY)) begin
          retry_d    = retry_q + RTW'(1);
          cnt_d      = '0;
          low_seen_d = 1'b0;
          state_d    = S_CMD;
        end else begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flops follow the next state so they align with it.
    req_ready_d  = (state_d == S_IDLE) && !ulpi_dir;
    rsp_valid_d  = (state_d == S_RESP);
    rsp_error_d  = (state_d == S_RESP) && err_d;
    cmd_strobe_d = (state_d == S_CMD) || (state_d == S_WR_DATA);
    stp_d        = (state_d == S_WR_STP);
    if (state_d == S_CMD)          cmd_d = {1'b1, ~wr_d, addr_d};
    else if (state_d == S_WR_DATA) cmd_d = wdata_d;
    else                           cmd_d = 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      retry_q      <= '0;
      low_seen_q   <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      cmd_q        <= '0;
      cmd_strobe_q <= 1'b0;
      stp_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      low_seen_q   <= low_seen_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_error_q  <= rsp_error_d;
      cmd_q        <= cmd_d;
      cmd_strobe_q <= cmd_strobe_d;
      stp_q        <= stp_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_error  = rsp_error_q;
  assign cmd        = cmd_q;
  assign cmd_strobe = cmd_strobe_q;
  assign stp        = stp_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ulpi_reg_ctrl
//
// Bench for ulpi_reg_ctrl. The bench plays both the requester and the PHY.
// Inputs are driven and outputs sampled on the falling clock edge. Each
// accepted request pushes its expected response onto a queue; a monitor pops
// and compares whenever rsp_valid is seen. Scenario tasks check the ULPI-side
// sequencing inline.
// ---------------------------------------------------------------------------
module tb_ulpi_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_error;
  logic [7:0] rsp_rdata;
  logic       ulpi_dir, ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic [7:0] cmd;
  logic       cmd_strobe, stp;

  typedef struct {
    logic       wr;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_total   = 0;
  int   n_pass    = 0;
  int   stp_count = 0;
  int   rsp_count = 0;

  ulpi_reg_ctrl #(.TIMEOUT_CYCLES(64), .MAX_RETRY(3), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .ulpi_dir     (ulpi_dir),
    .ulpi_nxt     (ulpi_nxt),
    .ulpi_data_in (ulpi_data_in),
    .cmd          (cmd),
    .cmd_strobe   (cmd_strobe),
    .stp          (stp)
  );

  always #5 clk = ~clk;

  // Response scoreboard and stp activity counter.
  always @(negedge clk) begin
    if (!reset) begin
      if (stp) stp_count++;
      if (rsp_valid) begin
        rsp_count++;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_rsp: got rsp_valid=1 err=%0b, want no response", rsp_error);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_error !== e.err)
            $display("FAIL sb_rsp_error: got %0b want %0b", rsp_error, e.err);
          else if (!e.wr && !e.err && rsp_rdata !== e.rdata)
            $display("FAIL sb_rsp_rdata: got %02h want %02h", rsp_rdata, e.rdata);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Waits for req_ready, presents one request for one cycle and records the
  // expected response. Returns at the falling edge of the first CMD cycle.
  task automatic send_req(input logic wr, input logic [5:0] addr, input logic [7:0] wdata,
                          input logic exp_err, input logic [7:0] exp_rdata);
    exp_t e;
    int   waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_total++;
    if (req_ready !== 1'b1) begin
      $display("FAIL req_ready_wait: got %0b want 1 within 20 cycles", req_ready);
    end else begin
      n_pass++;
    end
    e.wr = wr; e.err = exp_err; e.rdata = exp_rdata;
    sb.push_back(e);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    n_total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_error, cmd, cmd_strobe, stp} !== 20'h0)
      $display("FAIL reset_outputs: got %05h want 00000",
               {req_ready, rsp_valid, rsp_rdata, rsp_error, cmd, cmd_strobe, stp});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", req_ready);
    else n_pass++;
  endtask

  // Write with cmd_stall/data_stall cycles of nxt low before each acceptance.
  task automatic run_write(input logic [5:0] addr, input logic [7:0] wdata,
                           input int cmd_stall, input int data_stall, input string tag);
    logic [7:0] exp_cmd;
    int         bad = 0;
    int         stp0;
    exp_cmd = {2'b10, addr};
    stp0 = stp_count;
    send_req(1'b1, addr, wdata, 1'b0, 8'h00);
    for (int i = 0; i < cmd_stall; i++) begin
      if (cmd !== exp_cmd || cmd_strobe !== 1'b1 || rsp_valid !== 1'b0) bad++;
      tick();
    end
    n_total++;
    if (cmd !== exp_cmd || cmd_strobe !== 1'b1 || bad != 0)
      $display("FAIL %s_cmd: got cmd=%02h strobe=%0b stalls_bad=%0d want %02h 1 0",
               tag, cmd, cmd_strobe, bad, exp_cmd);
    else n_pass++;
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    for (int i = 0; i < data_stall; i++) begin
      if (cmd !== wdata || cmd_strobe !== 1'b1 || rsp_valid !== 1'b0) bad++;
      tick();
    end
    n_total++;
    if (cmd !== wdata || cmd_strobe !== 1'b1 || stp !== 1'b0 || bad != 0)
      $display("FAIL %s_data: got cmd=%02h strobe=%0b stp=%0b stalls_bad=%0d want %02h 1 0",
               tag, cmd, cmd_strobe, stp, bad, wdata);
    else n_pass++;
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    n_total++;
    if (stp !== 1'b1 || cmd_strobe !== 1'b0 || cmd !== 8'h00 || rsp_valid !== 1'b0)
      $display("FAIL %s_stp: got stp=%0b strobe=%0b cmd=%02h rsp=%0b want 1 0 00 0",
               tag, stp, cmd_strobe, cmd, rsp_valid);
    else n_pass++;
    tick();
    n_total++;
    if (rsp_valid !== 1'b1 || stp !== 1'b0 || stp_count - stp0 != 1)
      $display("FAIL %s_rsp: got rsp_valid=%0b stp=%0b stp_cycles=%0d want 1 0 1",
               tag, rsp_valid, stp, stp_count - stp0);
    else n_pass++;
    tick();
  endtask

  task automatic test_write;
    run_write(6'h0A, 8'h55, 0, 0, "write");
  endtask

  task automatic test_write_stall;
    run_write(6'h2C, 8'hC3, 5, 3, "write_stall");
  endtask

  task automatic test_read;
    int stp0;
    stp0 = stp_count;
    send_req(1'b0, 6'h01, 8'h00, 1'b0, 8'h24);
    n_total++;
    if (cmd !== 8'hC1 || cmd_strobe !== 1'b1)
      $display("FAIL read_cmd: got %02h strobe=%0b want c1 1", cmd, cmd_strobe);
    else n_pass++;
    ulpi_nxt = 1'b1;
    tick();
    n_total++;
    if (cmd_strobe !== 1'b0) $display("FAIL read_turn: got strobe=%0b want 0", cmd_strobe);
    else n_pass++;
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
    tick();
    ulpi_data_in = 8'h24;
    tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h24 || stp_count != stp0)
      $display("FAIL read_rsp: got valid=%0b rdata=%02h stp_cycles=%0d want 1 24 0",
               rsp_valid, rsp_rdata, stp_count - stp0);
    else n_pass++;
    tick();
  endtask

  task automatic test_preempt;
    int bad = 0;
    send_req(1'b1, 6'h03, 8'hA5, 1'b0, 8'h00);
    ulpi_dir = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_strobe !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL preempt_strobe_low: got %0d strobe-high cycles want 0", bad);
    else n_pass++;
    ulpi_dir = 1'b0;
    tick();
    n_total++;
    if (cmd_strobe !== 1'b0) $display("FAIL preempt_turnaround: got strobe=%0b want 0", cmd_strobe);
    else n_pass++;
    tick();
    n_total++;
    if (cmd_strobe !== 1'b1 || cmd !== 8'h83)
      $display("FAIL preempt_reissue: got strobe=%0b cmd=%02h want 1 83", cmd_strobe, cmd);
    else n_pass++;
    ulpi_nxt = 1'b1;
    tick();
    tick();
    ulpi_nxt = 1'b0;
    n_total++;
    if (stp !== 1'b1) $display("FAIL preempt_stp: got %0b want 1", stp);
    else n_pass++;
    tick();
    n_total++;
    if (rsp_valid !== 1'b1) $display("FAIL preempt_rsp: got %0b want 1", rsp_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_retry_exhaust;
    int attempts = 0;
    int bad      = 0;
    logic got;
    send_req(1'b0, 6'h3F, 8'h00, 1'b1, 8'h00);
    for (int p = 0; p < 4; p++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        if (cmd_strobe === 1'b1) got = 1'b1;
        else tick();
      end
      if (got) attempts++;
      ulpi_dir = 1'b1;
      repeat (3) tick();
      ulpi_dir = 1'b0;
    end
    n_total++;
    if (attempts != 4) $display("FAIL retry_attempts: got %0d want 4", attempts);
    else n_pass++;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      if (cmd_strobe !== 1'b0) bad++;
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    n_total++;
    if (!got || bad != 0)
      $display("FAIL retry_exhaust_rsp: got rsp=%0b extra_strobes=%0d want 1 0", got, bad);
    else n_pass++;
    tick();
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL retry_idle_ready: got %0b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_read_no_turn;
    send_req(1'b0, 6'h05, 8'h00, 1'b1, 8'h00);
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    tick();
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 8'h24)
      $display("FAIL no_turn_rsp: got valid=%0b err=%0b rdata=%02h want 1 1 24",
               rsp_valid, rsp_error, rsp_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout;
    int bad = 0;
    int stp0;
    stp0 = stp_count;
    send_req(1'b1, 6'h07, 8'h11, 1'b1, 8'h00);
    for (int i = 0; i < 64; i++) begin
      if (rsp_valid !== 1'b0 || cmd_strobe !== 1'b1) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL timeout_early: got %0d bad stall cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || cmd_strobe !== 1'b0 || stp_count != stp0)
      $display("FAIL timeout_rsp: got valid=%0b err=%0b strobe=%0b stp_cycles=%0d want 1 1 0 0",
               rsp_valid, rsp_error, cmd_strobe, stp_count - stp0);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_read;
    int seen0;
    exp_t dropped;
    send_req(1'b0, 6'h12, 8'h00, 1'b0, 8'h99);
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
    tick();
    ulpi_data_in = 8'h99;
    reset = 1'b1;
    dropped = sb.pop_back();
    #1;
    n_total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_error, cmd, cmd_strobe, stp} !== 20'h0)
      $display("FAIL midreset_outputs: got %05h want 00000",
               {req_ready, rsp_valid, rsp_rdata, rsp_error, cmd, cmd_strobe, stp});
    else n_pass++;
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    tick();
    reset = 1'b0;
    seen0 = rsp_count;
    repeat (10) tick();
    n_total++;
    if (rsp_count != seen0 || req_ready !== 1'b1 || dropped.rdata !== 8'h99)
      $display("FAIL midreset_no_rsp: got rsps=%0d ready=%0b want 0 1", rsp_count - seen0, req_ready);
    else n_pass++;
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = '0;
    test_reset();
    test_write();
    test_read();
    test_write_stall();
    test_preempt();
    test_retry_exhaust();
    test_read_no_turn();
    test_timeout();
    test_reset_mid_read();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
